// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares the register-file write port among NREQ writeback requesters.
// Optional destination-register scoreboard (pending flags) is built when RFARB_SCOREBOARD_EN is defined.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic                 RegWre,
    output logic [AW-1:0]        WriteReg,
    output logic [DW-1:0]        WriteData,
    input  logic                 rsv_valid,
    input  logic [AW-1:0]        rsv_reg,
    output logic [(1<<AW)-1:0]   pending,
    output logic                 arb_busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NREG = 1 << AW;
    localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            regwre_q, regwre_d;
    logic [AW-1:0]   write_reg_q, write_reg_d;
    logic [DW-1:0]   write_data_q, write_data_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            arb_busy_q, arb_busy_d;

    logic [NREQ-1:0] elig;
    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   cand;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_data;

    // A requester granted last cycle is masked so a still-held request is not accepted twice.
    assign elig = req & ~gnt_q;

    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr_q;
        cand      = rr_ptr_q;
        for (int off = 1; off <= NREQ; off++) begin
            cand = PW'((int'(rr_ptr_q) + off) % NREQ);
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_addr = req_addr[int'(win_idx)*AW +: AW];
    assign win_data = req_data[int'(win_idx)*DW +: DW];

    always_comb begin
        gnt_d        = '0;
        regwre_d     = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        rr_ptr_d     = rr_ptr_q;
        arb_busy_d   = |elig;
        if (win_found) begin
            gnt_d[win_idx] = 1'b1;
            regwre_d       = (win_addr != '0);
            write_reg_d    = win_addr;
            write_data_d   = win_data;
            rr_ptr_d       = win_idx;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            gnt_q        <= '0;
            regwre_q     <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            rr_ptr_q     <= PTR_RST;
            arb_busy_q   <= 1'b0;
        end else begin
            gnt_q        <= gnt_d;
            regwre_q     <= regwre_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            rr_ptr_q     <= rr_ptr_d;
            arb_busy_q   <= arb_busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign RegWre    = regwre_q;
    assign WriteReg  = write_reg_q;
    assign WriteData = write_data_q;
    assign arb_busy  = arb_busy_q;

`ifdef RFARB_SCOREBOARD_EN
    logic [NREG-1:0] pending_q, pending_d;

    // Reservation is applied after the clear so a same-cycle set of the written register wins.
    always_comb begin
        pending_d = pending_q;
        if (win_found && regwre_d) begin
            pending_d[win_addr] = 1'b0;
        end
        if (rsv_valid && (rsv_reg != '0)) begin
            pending_d[rsv_reg] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;
`else
    logic unused_rsv;
    assign unused_rsv = rsv_valid ^ (|rsv_reg);
    assign pending    = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scoreboard bench for regfile_wb_arbiter (NREQ=3, AW=5, DW=32) with a small register-file model.
module tb_regfile_wb_arbiter;
    logic          CLK;
    logic          RST_n;
    logic [2:0]    req;
    logic [14:0]   req_addr;
    logic [95:0]   req_data;
    logic [2:0]    gnt;
    logic          RegWre;
    logic [4:0]    WriteReg;
    logic [31:0]   WriteData;
    logic          rsv_valid;
    logic [4:0]    rsv_reg;
    logic [31:0]   pending;
    logic          arb_busy;

    logic [4:0]    addr [3];
    logic [31:0]   data [3];
    logic [31:0]   rf [32];

    typedef struct packed {
        logic [2:0]  gnt;
        logic        regwre;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    assign req_addr = {addr[2], addr[1], addr[0]};
    assign req_data = {data[2], data[1], data[0]};

    regfile_wb_arbiter #(.NREQ(3), .AW(5), .DW(32)) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .req       (req),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .gnt       (gnt),
        .RegWre    (RegWre),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .rsv_valid (rsv_valid),
        .rsv_reg   (rsv_reg),
        .pending   (pending),
        .arb_busy  (arb_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register-file model commits on the negedge following a registered write.
    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
    end
    always @(negedge CLK) begin
        if (RegWre) rf[WriteReg] <= WriteData;
    end

    function automatic exp_t mk(input logic [2:0] g, input logic w, input logic [4:0] r,
                                input logic [31:0] d, input logic b);
        exp_t e;
        e.gnt = g; e.regwre = w; e.wreg = r; e.wdata = d; e.busy = b;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] r, input exp_t e, input string tag);
        exp_t cur;
        @(negedge CLK);
        req = r;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        cur = exp_q.pop_front();
        checkOutput({tag, "/gnt"},    32'(gnt),       32'(cur.gnt));
        checkOutput({tag, "/regwre"}, 32'(RegWre),    32'(cur.regwre));
        checkOutput({tag, "/wreg"},   32'(WriteReg),  32'(cur.wreg));
        checkOutput({tag, "/wdata"},  WriteData,      cur.wdata);
        checkOutput({tag, "/busy"},   32'(arb_busy),  32'(cur.busy));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST_n = 1'b1; req = '0; rsv_valid = 1'b0; rsv_reg = '0;
        for (int i = 0; i < 3; i++) begin addr[i] = '0; data[i] = '0; end

        // Asynchronous reset in the middle of the first cycle.
        #3 RST_n = 1'b0;
        #1;
        checkOutput("rst/gnt",     32'(gnt),       32'h0);
        checkOutput("rst/regwre",  32'(RegWre),    32'h0);
        checkOutput("rst/wreg",    32'(WriteReg),  32'h0);
        checkOutput("rst/wdata",   WriteData,      32'h0);
        checkOutput("rst/pending", pending,        32'h0);
        checkOutput("rst/busy",    32'(arb_busy),  32'h0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_n = 1'b1;

        $display("[TB] round robin with all requesters");
        addr[0] = 5'd1; addr[1] = 5'd2; addr[2] = 5'd3;
        data[0] = 32'hA0; data[1] = 32'hA1; data[2] = 32'hA2;
        applyStimulus(3'b111, mk(3'b001, 1, 5'd1, 32'hA0, 1), "rr1");
        applyStimulus(3'b111, mk(3'b010, 1, 5'd2, 32'hA1, 1), "rr2");
        applyStimulus(3'b111, mk(3'b100, 1, 5'd3, 32'hA2, 1), "rr3");
        applyStimulus(3'b111, mk(3'b001, 1, 5'd1, 32'hA0, 1), "rr4");
        applyStimulus(3'b111, mk(3'b010, 1, 5'd2, 32'hA1, 1), "rr5");
        applyStimulus(3'b111, mk(3'b100, 1, 5'd3, 32'hA2, 1), "rr6");

        $display("[TB] single requester masking");
        addr[1] = 5'd5; data[1] = 32'hDEADBEEF;
        applyStimulus(3'b010, mk(3'b010, 1, 5'd5, 32'hDEADBEEF, 1), "single_gnt");
        applyStimulus(3'b010, mk(3'b000, 0, 5'd5, 32'hDEADBEEF, 0), "single_mask");
        applyStimulus(3'b010, mk(3'b010, 1, 5'd5, 32'hDEADBEEF, 1), "single_regnt");
        applyStimulus(3'b000, mk(3'b000, 0, 5'd5, 32'hDEADBEEF, 0), "single_idle");
        checkOutput("rf_r5", rf[5], 32'hDEADBEEF);

        $display("[TB] address zero");
        addr[0] = 5'd0; data[0] = 32'h1234;
        applyStimulus(3'b001, mk(3'b001, 0, 5'd0, 32'h1234, 1), "r0_gnt");
        applyStimulus(3'b000, mk(3'b000, 0, 5'd0, 32'h1234, 0), "r0_idle");
        checkOutput("rf_r0", rf[0], 32'h0);

        $display("[TB] fairness between 0 and 2");
        addr[0] = 5'd8; data[0] = 32'hB0; addr[2] = 5'd9; data[2] = 32'hB2;
        applyStimulus(3'b101, mk(3'b100, 1, 5'd9, 32'hB2, 1), "fair1");
        applyStimulus(3'b101, mk(3'b001, 1, 5'd8, 32'hB0, 1), "fair2");
        applyStimulus(3'b101, mk(3'b100, 1, 5'd9, 32'hB2, 1), "fair3");
        applyStimulus(3'b101, mk(3'b001, 1, 5'd8, 32'hB0, 1), "fair4");
        applyStimulus(3'b000, mk(3'b000, 0, 5'd8, 32'hB0, 0), "fair_idle");

        $display("[TB] reset during a registered write");
        addr[2] = 5'd10; data[2] = 32'hC2;
        applyStimulus(3'b100, mk(3'b100, 1, 5'd10, 32'hC2, 1), "pre_rst");
        #1 RST_n = 1'b0;
        #1;
        checkOutput("midrst/gnt",    32'(gnt),      32'h0);
        checkOutput("midrst/regwre", 32'(RegWre),   32'h0);
        checkOutput("midrst/wreg",   32'(WriteReg), 32'h0);
        checkOutput("midrst/wdata",  WriteData,     32'h0);
        checkOutput("midrst/busy",   32'(arb_busy), 32'h0);
        req = '0;
        @(negedge CLK);
        #1;
        checkOutput("rf_r10_dropped", rf[10], 32'h0);
        RST_n = 1'b1;
        addr[0] = 5'd11; data[0] = 32'hD0; addr[2] = 5'd12; data[2] = 32'hD2;
        applyStimulus(3'b101, mk(3'b001, 1, 5'd11, 32'hD0, 1), "post_rst1");
        applyStimulus(3'b101, mk(3'b100, 1, 5'd12, 32'hD2, 1), "post_rst2");
        applyStimulus(3'b000, mk(3'b000, 0, 5'd12, 32'hD2, 0), "post_rst_idle");

        $display("[TB] destination reservation");
        rsv_valid = 1'b1; rsv_reg = 5'd7;
        applyStimulus(3'b000, mk(3'b000, 0, 5'd12, 32'hD2, 0), "rsv7");
`ifdef RFARB_SCOREBOARD_EN
        checkOutput("pend_set7", pending, 32'h0000_0080);
`else
        checkOutput("pend_set7", pending, 32'h0);
`endif
        rsv_valid = 1'b0;
        addr[0] = 5'd7; data[0] = 32'hE0;
        applyStimulus(3'b001, mk(3'b001, 1, 5'd7, 32'hE0, 1), "wr7");
        checkOutput("pend_clr7", pending, 32'h0);
        rsv_valid = 1'b1; rsv_reg = 5'd7;
        addr[1] = 5'd7; data[1] = 32'hE1;
        applyStimulus(3'b010, mk(3'b010, 1, 5'd7, 32'hE1, 1), "rsv_wr7");
`ifdef RFARB_SCOREBOARD_EN
        checkOutput("pend_setwins7", pending, 32'h0000_0080);
`else
        checkOutput("pend_setwins7", pending, 32'h0);
`endif
        rsv_reg = 5'd0;
        applyStimulus(3'b000, mk(3'b000, 0, 5'd7, 32'hE1, 0), "rsv0");
`ifdef RFARB_SCOREBOARD_EN
        checkOutput("pend_r0_ignored", pending, 32'h0000_0080);
`else
        checkOutput("pend_r0_ignored", pending, 32'h0);
`endif
        rsv_valid = 1'b0;
        checkOutput("rf_r7", rf[7], 32'hE1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
